ts_stream_arbiter: RTL
======================

TS_STREAM_ARBITER -- requirements
Module: ts_stream_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, sets the byte width of the channel and output data.
REQ-002 Parameter PKT_LEN, default 188, sets the bytes per TS packet; legal range is 4..255.
REQ-003 clk  in  1  single clock domain (100 MHz system); one clock, asynchronous active-low reset.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 pkt_rdy  in  4  bit i high = channel i FIFO holds at least one complete packet.
REQ-006 rd_en  out  4  one-hot FIFO read strobe; data is returned the following cycle.
REQ-007 ch_data0..ch_data3  in  DATA_WIDTH each  FIFO read data, valid the cycle after rd_en[i].
REQ-008 out_data  out  DATA_WIDTH  muxed TS byte stream.
REQ-009 out_valid / out_sop / out_eop  out  1 each  byte valid / first byte of packet / last byte of packet.
REQ-010 mm_addr  in  8; mm_wdata  in  32; mm_write_en  in  1; mm_read_en  in  1; mm_rdata  out  32  memory-mapped config port.

Function
REQ-011 The FSM SHALL have states IDLE, GRANT, XFER, DRAIN and GAP.
REQ-012 IDLE->GRANT SHALL occur when CTRL.en=1 and (pkt_rdy & CTRL.mask) is non-zero.
REQ-013 In GRANT (1 cycle), the winner SHALL be latched into grant[1:0].
  - Mode 0 (round-robin): search starts at last_grant+1, mod 4.
  - Mode 1 (fixed priority): ch0 is highest.
REQ-014 In XFER, rd_en[grant] SHALL be high for exactly PKT_LEN consecutive cycles, counted by byte_cnt 0..PKT_LEN-1; XFER->DRAIN after the last read.
REQ-015 DRAIN (1 cycle) SHALL flush the pipeline, then go to GAP if GAP.len>0, else IDLE.
REQ-016 GAP SHALL idle for GAP.len cycles, then go to IDLE.
REQ-017 Outputs SHALL be registered, so out_* appears 2 cycles after the corresponding rd_en.
  - out_sop marks byte 0; out_eop marks byte PKT_LEN-1.
  - out_valid is contiguous for PKT_LEN cycles.
REQ-018 Minimum spacing SHALL be one packet per PKT_LEN+3 cycles with GAP.len=0.
REQ-019 CTRL changes mid-packet SHALL only take effect at the next GRANT.
  - Clearing CTRL.en or a mask bit never truncates a packet in flight.
REQ-020 pkt_rdy dropping during XFER SHALL be ignored, since the FIFO is guaranteed to hold the full packet.
REQ-021 On out_eop, pkt_cnt[grant] SHALL increment, wrapping modulo 2^32.
REQ-022 Register map: write to 0x00/0x04 only; all other writes are ignored.
  - 0x00 CTRL: [0] en, [7:4] mask, [8] mode, [31] clr (self-clearing, zeroes all counters).
  - 0x04 GAP: [7:0] len.
  - 0x08 STATUS (RO): [1:0] grant, [2] busy (state != IDLE).
  - 0x10/0x14/0x18/0x1C (RO): pkt_cnt0..3.
  - 0x20 (RO): sync_err_cnt.
REQ-023 mm_rdata SHALL be updated on the clock edge where mm_read_en is sampled high and SHALL hold until the next read.
  - Unmapped addresses read 0.
REQ-024 When a counter clear and a counter increment occur in the same cycle, the clear SHALL win.
REQ-025 Simultaneous mm_write_en and mm_read_en to the same address SHALL return the old value and apply the write.

Reset
REQ-026 While reset_n is low, the following SHALL be cleared:
  - state=IDLE, rd_en=0, out_valid/sop/eop=0, out_data=0;
  - grant=0, last_grant=3 (so ch0 wins first in mode 0);
  - CTRL=0, GAP=0, all counters=0, mm_rdata=0.
REQ-027 Reset asserted mid-packet SHALL abort immediately; after reset release, the next grant starts a fresh packet.

Configuration
REQ-028 Macro TS_SYNC_CHECK_EN, when defined, SHALL enable sync checking on byte 0 of each packet.
  - If byte 0 != 0x47, out_valid/sop/eop are suppressed for that whole packet.
  - All PKT_LEN bytes are still read, to keep the FIFO aligned.
  - sync_err_cnt increments by 1 and pkt_cnt is not incremented.
REQ-029 When TS_SYNC_CHECK_EN is undefined, all packets SHALL be forwarded unchecked, and 0x20 reads 0.

Verification
REQ-030 CTRL=0x0F1, pkt_rdy=4'b1111 held -> grants 0,1,2,3,0; each 188-byte burst on the correct rd_en bit.
REQ-031 CTRL=0x1F1, pkt_rdy=4'b1010 -> grants repeat ch1 only; pkt_cnt1 increments and pkt_cnt3=0.
REQ-032 GAP=5, single channel -> rd_en rising edges are 188+3+5=196 cycles apart.
  - out_sop occurs 2 cycles after the first rd_en.
REQ-033 Write CTRL.en=0 at byte 100 of a packet -> the packet completes with out_eop, then the FSM stays in IDLE.
REQ-034 With TS_SYNC_CHECK_EN, feed byte 0=0x46 -> no out_valid for that packet and 0x20 reads 1.
  - The next packet with byte 0=0x47 is forwarded.
REQ-035 Write CTRL[31]=1 in the same cycle as an out_eop -> all counters read 0 afterwards.
  - Assert reset_n low mid-XFER -> rd_en and out_valid drop immediately.

Source files
------------

// File: rtl/ts_stream_arbiter_if.sv
// rtl/ts_stream_arbiter_if.sv - FIFO, TS stream and register bus bundle for ts_stream_arbiter
interface ts_stream_arbiter_if #(
  parameter int DATA_WIDTH = 8
);
  logic [3:0]            pkt_rdy;
  logic [3:0]            rd_en;
  logic [DATA_WIDTH-1:0] ch_data0;
  logic [DATA_WIDTH-1:0] ch_data1;
  logic [DATA_WIDTH-1:0] ch_data2;
  logic [DATA_WIDTH-1:0] ch_data3;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_sop;
  logic                  out_eop;
  logic [7:0]            mm_addr;
  logic [31:0]           mm_wdata;
  logic                  mm_write_en;
  logic                  mm_read_en;
  logic [31:0]           mm_rdata;

  modport master (
    output pkt_rdy, ch_data0, ch_data1, ch_data2, ch_data3,
    output mm_addr, mm_wdata, mm_write_en, mm_read_en,
    input  rd_en, out_data, out_valid, out_sop, out_eop, mm_rdata
  );

  modport slave (
    input  pkt_rdy, ch_data0, ch_data1, ch_data2, ch_data3,
    input  mm_addr, mm_wdata, mm_write_en, mm_read_en,
    output rd_en, out_data, out_valid, out_sop, out_eop, mm_rdata
  );
endinterface

// File: rtl/ts_stream_arbiter.sv
// rtl/ts_stream_arbiter.sv - 4-channel TS packet arbiter muxing FIFO reads into one byte stream
// Optional feature macro TS_SYNC_CHECK_EN: drop packets whose first byte is not 0x47.
module ts_stream_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 188
) (
  input  logic               clk,
  input  logic               reset_n,
  ts_stream_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, GRANT, XFER, DRAIN, GAP} state_t;

  localparam logic [31:0] CTRL_WMASK = 32'h0000_01F1;
  localparam logic [7:0]  LAST_BYTE  = 8'(PKT_LEN - 1);

  state_t                state_q, state_d;
  logic [7:0]            byte_cnt_q, byte_cnt_d;
  logic [7:0]            gap_cnt_q, gap_cnt_d;
  logic [1:0]            grant_q, grant_d;
  logic [1:0]            last_grant_q, last_grant_d;
  logic [31:0]           ctrl_q, ctrl_d;
  logic [7:0]            gap_q, gap_d;
  logic [31:0]           mm_rdata_q, mm_rdata_d;
  logic [31:0]           pkt_cnt_q [4];
  logic [31:0]           pkt_cnt_d [4];
  logic [31:0]           sync_err_cnt_q, sync_err_cnt_d;
  logic                  s1_valid_q, s1_valid_d;
  logic                  s1_sop_q, s1_sop_d;
  logic                  s1_eop_q, s1_eop_d;
  logic [1:0]            s1_ch_q, s1_ch_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_sop_q, out_sop_d;
  logic                  out_eop_q, out_eop_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]            out_ch_q, out_ch_d;
  logic                  drop_q, drop_d;
  logic                  drop_eop_q, drop_eop_d;

  logic [3:0]            req;
  logic [1:0]            win;
  logic [1:0]            idx;
  logic                  win_found;
  logic [DATA_WIDTH-1:0] ch_sel;
  logic                  sync_bad;
  logic                  drop_now;
  logic                  fwd;
  logic                  clr;

  // Winner search uses the live CTRL, so mode/mask edits land at the next GRANT.
  always_comb begin
    req       = bus.pkt_rdy & ctrl_q[7:4];
    win       = 2'd0;
    win_found = 1'b0;
    idx       = 2'd0;
    if (ctrl_q[8]) begin
      for (int i = 0; i < 4; i++) begin
        if (!win_found && req[i]) begin
          win       = 2'(i);
          win_found = 1'b1;
        end
      end
    end else begin
      for (int k = 1; k <= 4; k++) begin
        idx = last_grant_q + 2'(k);
        if (!win_found && req[idx]) begin
          win       = idx;
          win_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: if (ctrl_q[0] && (req != 4'b0)) state_d = GRANT;
      GRANT: begin
        if (win_found) begin
          grant_d      = win;
          last_grant_d = win;
          byte_cnt_d   = 8'd0;
          state_d      = XFER;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        if (byte_cnt_q == LAST_BYTE) state_d = DRAIN;
        else byte_cnt_d = byte_cnt_q + 8'd1;
      end
      DRAIN: begin
        gap_cnt_d = gap_q;
        state_d   = (gap_q != 8'd0) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_cnt_q <= 8'd1) state_d = IDLE;
        else gap_cnt_d = gap_cnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rd_en = (state_q == XFER) ? (4'b0001 << grant_q) : 4'b0000;

  always_comb begin
    case (s1_ch_q)
      2'd0:    ch_sel = bus.ch_data0;
      2'd1:    ch_sel = bus.ch_data1;
      2'd2:    ch_sel = bus.ch_data2;
      default: ch_sel = bus.ch_data3;
    endcase
  end

`ifdef TS_SYNC_CHECK_EN
  localparam logic [DATA_WIDTH-1:0] SYNC_BYTE = DATA_WIDTH'(8'h47);
  assign sync_bad = s1_sop_q && (ch_sel != SYNC_BYTE);
`else
  assign sync_bad = 1'b0;
`endif

  // Stage 1 tags the byte being read; the output stage captures the FIFO data a cycle later.
  always_comb begin
    s1_valid_d  = (state_q == XFER);
    s1_sop_d    = s1_valid_d && (byte_cnt_q == 8'd0);
    s1_eop_d    = s1_valid_d && (byte_cnt_q == LAST_BYTE);
    s1_ch_d     = grant_q;
    drop_now    = s1_sop_q ? sync_bad : drop_q;
    drop_d      = s1_valid_q ? drop_now : drop_q;
    fwd         = s1_valid_q && !drop_now;
    out_valid_d = fwd;
    out_sop_d   = fwd && s1_sop_q;
    out_eop_d   = fwd && s1_eop_q;
    out_data_d  = fwd ? ch_sel : '0;
    out_ch_d    = s1_ch_q;
    drop_eop_d  = s1_valid_q && s1_eop_q && drop_now;
  end

  always_comb begin
    ctrl_d = ctrl_q;
    gap_d  = gap_q;
    clr    = 1'b0;
    if (bus.mm_write_en) begin
      case (bus.mm_addr)
        8'h00: begin
          ctrl_d = bus.mm_wdata & CTRL_WMASK;
          clr    = bus.mm_wdata[31];
        end
        8'h04:   gap_d = bus.mm_wdata[7:0];
        default: ;
      endcase
    end
    for (int i = 0; i < 4; i++) pkt_cnt_d[i] = pkt_cnt_q[i];
    if (out_eop_q) pkt_cnt_d[out_ch_q] = pkt_cnt_q[out_ch_q] + 32'd1;
    sync_err_cnt_d = sync_err_cnt_q + (drop_eop_q ? 32'd1 : 32'd0);
    // Clear overrides any increment landing on the same edge.
    if (clr) begin
      for (int i = 0; i < 4; i++) pkt_cnt_d[i] = 32'd0;
      sync_err_cnt_d = 32'd0;
    end
  end

  always_comb begin
    mm_rdata_d = mm_rdata_q;
    if (bus.mm_read_en) begin
      case (bus.mm_addr)
        8'h00:   mm_rdata_d = ctrl_q;
        8'h04:   mm_rdata_d = {24'd0, gap_q};
        8'h08:   mm_rdata_d = {29'd0, (state_q != IDLE), grant_q};
        8'h10:   mm_rdata_d = pkt_cnt_q[0];
        8'h14:   mm_rdata_d = pkt_cnt_q[1];
        8'h18:   mm_rdata_d = pkt_cnt_q[2];
        8'h1C:   mm_rdata_d = pkt_cnt_q[3];
        8'h20:   mm_rdata_d = sync_err_cnt_q;
        default: mm_rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      byte_cnt_q     <= 8'd0;
      gap_cnt_q      <= 8'd0;
      grant_q        <= 2'd0;
      last_grant_q   <= 2'd3;
      ctrl_q         <= 32'd0;
      gap_q          <= 8'd0;
      mm_rdata_q     <= 32'd0;
      for (int i = 0; i < 4; i++) pkt_cnt_q[i] <= 32'd0;
      sync_err_cnt_q <= 32'd0;
      s1_valid_q     <= 1'b0;
      s1_sop_q       <= 1'b0;
      s1_eop_q       <= 1'b0;
      s1_ch_q        <= 2'd0;
      out_valid_q    <= 1'b0;
      out_sop_q      <= 1'b0;
      out_eop_q      <= 1'b0;
      out_data_q     <= '0;
      out_ch_q       <= 2'd0;
      drop_q         <= 1'b0;
      drop_eop_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      byte_cnt_q     <= byte_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      grant_q        <= grant_d;
      last_grant_q   <= last_grant_d;
      ctrl_q         <= ctrl_d;
      gap_q          <= gap_d;
      mm_rdata_q     <= mm_rdata_d;
      for (int i = 0; i < 4; i++) pkt_cnt_q[i] <= pkt_cnt_d[i];
      sync_err_cnt_q <= sync_err_cnt_d;
      s1_valid_q     <= s1_valid_d;
      s1_sop_q       <= s1_sop_d;
      s1_eop_q       <= s1_eop_d;
      s1_ch_q        <= s1_ch_d;
      out_valid_q    <= out_valid_d;
      out_sop_q      <= out_sop_d;
      out_eop_q      <= out_eop_d;
      out_data_q     <= out_data_d;
      out_ch_q       <= out_ch_d;
      drop_q         <= drop_d;
      drop_eop_q     <= drop_eop_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sop   = out_sop_q;
  assign bus.out_eop   = out_eop_q;
  assign bus.out_data  = out_data_q;
  assign bus.mm_rdata  = mm_rdata_q;
endmodule
